bus_sram_slave: RTL and testbench

- On-chip SRAM bus slave that answers the burst transactions issued by the custom-instruction DMA (`ramDmaCi`) and other bus masters.
- Sits directly downstream of the DMA/arbiter on the shared address/data bus:
  - receives begin/address/burst-size/read-not-write;
  - returns read bursts with `dataValidOut` and `endTransactionOut`;
  - absorbs write bursts, inserting `busyOut` stalls.
- Serves as the simulation memory for DMA benches and as a synthesizable scratch RAM.

---
 rtl/bus_sram_pkg.sv | 8 +
 rtl/bus_sram_if.sv | 23 ++
 rtl/bus_sram_bank.sv | 23 ++
 rtl/bus_sram_slave.sv | 74 +++++++
 tb/tb_bus_sram_slave.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/bus_sram_pkg.sv
// bus_sram_pkg: shared FSM encoding and widths for the SRAM bus slave
package bus_sram_pkg;
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, RD_END, WR_BURST, WR_WAIT_END, ERROR} state_t;
  localparam int LEN_W = 9;
  function automatic int word_aw(input int words);
    return words > 1 ? $clog2(words) : 1;
  endfunction
endpackage

// File: rtl/bus_sram_if.sv
// bus_sram_if: shared address/data burst bus between a master and the SRAM slave
interface bus_sram_if;
  logic        begin_transaction;
  logic [31:0] address_data;
  logic [7:0]  burst_size;
  logic        read_not_write;
  logic [3:0]  byte_enables;
  logic        data_valid;
  logic        end_transaction;
  logic [31:0] read_data;
  logic        read_valid;
  logic        slave_end;
  logic        bus_error;
  logic        busy;
  modport master(
    output begin_transaction, address_data, burst_size, read_not_write, byte_enables, data_valid, end_transaction,
    input  read_data, read_valid, slave_end, bus_error, busy
  );
  modport slave(
    input  begin_transaction, address_data, burst_size, read_not_write, byte_enables, data_valid, end_transaction,
    output read_data, read_valid, slave_end, bus_error, busy
  );
endinterface

// File: rtl/bus_sram_bank.sv
// bus_sram_bank: single-port synchronous 32-bit RAM with byte enables and one-cycle read
module bus_sram_bank import bus_sram_pkg::*; #(
  parameter int MEM_WORDS = 1024,
  localparam int AW = word_aw(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          re,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [MEM_WORDS];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  // read port idles at zero so it can drive the bus directly
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else rdata <= re ? mem[addr] : '0;
endmodule

// File: rtl/bus_sram_slave.sv
// bus_sram_slave: burst bus slave fronting a synchronous SRAM bank
module bus_sram_slave import bus_sram_pkg::*; #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int MEM_WORDS = 1024,
  parameter int READ_LATENCY = 2,
  parameter int BUSY_INTERVAL = 0
) (
  input logic clk,
  input logic rst_n,
  bus_sram_if.slave bus
);
  localparam int AW = word_aw(MEM_WORDS);
  localparam logic [3:0] WAIT_INIT = READ_LATENCY > 1 ? 4'(READ_LATENCY - 2) : 4'd0;
  state_t state, next;
  logic [32:0] diff;
  logic [AW-1:0] ptr, ptr_cur;
  logic [LEN_W-1:0] rem, rem_cur, bcnt;
  logic [3:0] cnt;
  logic [31:0] rdata;
  logic idle, addr_ok, issue, accept, hit, next_busy, next_end, next_err;
  assign idle = state == IDLE;
  assign diff = {1'b0, bus.address_data} - {1'b0, ADDR_BASE};
  assign addr_ok = bus.address_data[1:0] == 2'b00 && !diff[32] && (diff[31:0] >> 2) < 32'(MEM_WORDS);
  // in IDLE the pointer and remaining count come straight off the bus so a read can issue on the begin cycle
  assign ptr_cur = idle ? diff[AW+1:2] : ptr;
  assign rem_cur = idle ? LEN_W'(bus.burst_size) + LEN_W'(1) : rem;
  assign bus.read_data = rdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    if (!idle && bus.end_transaction) next = IDLE;
    else
      case (state)
        IDLE:        if (bus.begin_transaction)
                       next = !addr_ok ? ERROR : !bus.read_not_write ? WR_BURST : READ_LATENCY == 1 ? RD_BURST : RD_WAIT;
        RD_WAIT:     if (cnt == 0) next = RD_BURST;
        RD_BURST:    if (rem == 0) next = RD_END;
        WR_BURST:    if (accept && rem == 1) next = WR_WAIT_END;
        RD_END:      next = IDLE;
        ERROR:       next = IDLE;
        default:     next = state;
      endcase
  end
  // rem counts words not yet issued (read) or not yet accepted (write)
  always_comb begin
    issue = idle ? bus.begin_transaction && bus.read_not_write && addr_ok && READ_LATENCY == 1
                 : !bus.end_transaction && ((state == RD_WAIT && cnt == 0) || (state == RD_BURST && rem != 0));
    accept = state == WR_BURST && bus.data_valid && !bus.busy && !bus.end_transaction;
    hit = BUSY_INTERVAL > 0 && 32'(bcnt) == 32'(BUSY_INTERVAL - 1);
    next_busy = accept && hit && rem != 1;
    next_err = next == ERROR;
    next_end = next_err || next == RD_END;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      rem <= '0;
      cnt <= '0;
      bcnt <= '0;
      {bus.read_valid, bus.slave_end, bus.bus_error, bus.busy} <= '0;
    end else begin
      ptr <= ptr_cur + AW'(issue | accept);
      rem <= rem_cur - LEN_W'(issue | accept);
      cnt <= idle ? WAIT_INIT : cnt - 4'(cnt != 0);
      bcnt <= idle || (accept && hit) ? '0 : bcnt + LEN_W'(accept);
      {bus.read_valid, bus.slave_end, bus.bus_error, bus.busy} <= {issue, next_end, next_err, next_busy};
    end
  bus_sram_bank #(.MEM_WORDS(MEM_WORDS)) u_bank (
    .clk, .rst_n, .re(issue), .we(accept), .be(bus.byte_enables),
    .addr(ptr_cur), .wdata(bus.address_data), .rdata
  );
endmodule

// File: tb/tb_bus_sram_slave.sv
// tb_bus_sram_slave: table-driven and randomized checks of bus_sram_slave against a word-array model
module tb_bus_sram_slave;
  localparam int MEM = 1024;
  localparam int RL = 2;
  localparam int BI = 2;
  typedef struct {logic [31:0] addr; int len; logic err;} vec_t;
  logic clk, rst_n, end_at_begin;
  logic [31:0] model_mem [MEM];
  logic [31:0] wd [256];
  logic [3:0] wb [256];
  vec_t vecs [9];
  int n_cmp, n_err;
  bus_sram_if bus();
  bus_sram_slave #(.ADDR_BASE(32'h0), .MEM_WORDS(MEM), .READ_LATENCY(RL), .BUSY_INTERVAL(BI)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  function automatic logic [35:0] outs();
    return {bus.read_valid, bus.read_data, bus.slave_end, bus.bus_error, bus.busy};
  endfunction
  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic do_write(input logic [31:0] addr, input int len);
    int i, guard, idx;
    logic bexp;
    idx = int'(addr >> 2);
    @(posedge clk); #1;
    bus.begin_transaction = 1; bus.address_data = addr; bus.burst_size = 8'(len - 1);
    bus.read_not_write = 0; bus.data_valid = 0;
    i = 0; guard = 0; bexp = 0;
    while (i < len) begin
      @(posedge clk); #1;
      bus.begin_transaction = 0;
      check("wr_busy", outs(), {35'b0, bexp});
      bus.data_valid = 1; bus.byte_enables = wb[i];
      if (bus.busy) begin
        bus.address_data = ~wd[i];
        bexp = 0;
      end else begin
        bus.address_data = wd[i];
        for (int b = 0; b < 4; b++)
          if (wb[i][b]) model_mem[(idx + i) % MEM][8*b +: 8] = wd[i][8*b +: 8];
        i++;
        bexp = BI > 0 && i % BI == 0 && i != len;
      end
      guard++;
      if (guard > 2 * len + 4) begin
        n_cmp++; n_err++;
        $display("FAIL wr_timeout: accepted %0d of %0d words", i, len);
        break;
      end
    end
    @(posedge clk); #1;
    check("wr_tail", outs(), {35'b0, bexp});
    bus.address_data = 32'hBAD0_BAD0; bus.byte_enables = 4'hF;
    @(posedge clk); #1;
    bus.data_valid = 0; bus.end_transaction = 1;
    @(posedge clk); #1;
    bus.end_transaction = 0;
  endtask
  task automatic do_read(input logic [31:0] addr, input int len, input logic err);
    int idx;
    logic v;
    logic [31:0] d;
    idx = int'(addr >> 2);
    @(posedge clk); #1;
    bus.begin_transaction = 1; bus.address_data = addr; bus.burst_size = 8'(len - 1);
    bus.read_not_write = 1; bus.data_valid = 0; bus.end_transaction = end_at_begin;
    for (int k = 1; k <= (err ? 1 : RL + len); k++) begin
      @(posedge clk); #1;
      bus.begin_transaction = 0; bus.address_data = '0; bus.end_transaction = 0;
      v = !err && k >= RL && k < RL + len;
      d = v ? model_mem[(idx + k - RL) % MEM] : 32'h0;
      check(err ? "rd_error" : "rd_cycle", outs(), {v, d, err ? 1'b1 : k == RL + len, err, 1'b0});
    end
  endtask
  initial begin
    n_cmp = 0; n_err = 0; end_at_begin = 0;
    rst_n = 0;
    bus.begin_transaction = 0; bus.address_data = '0; bus.burst_size = '0; bus.read_not_write = 0;
    bus.byte_enables = '0; bus.data_valid = 0; bus.end_transaction = 0;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", outs(), 36'h0);
    rst_n = 1;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 256; i++) begin wd[i] = $urandom(); wb[i] = 4'hF; end
      do_write(32'(b * 1024), 256);
    end
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(10 * (i + 1)); wb[i] = 4'hF; end
    do_write(32'h0, 4);
    do_read(32'h0, 4, 0);
    wd[0] = 55; wd[1] = 66;
    do_write(32'h34, 2);
    do_read(32'h34, 2, 0);
    for (int i = 0; i < 5; i++) wd[i] = 32'(i + 1);
    do_write(32'h200, 5);
    do_read(32'h200, 5, 0);
    wd[0] = 32'hCAFE_F00D;
    do_write(32'(4 * (MEM - 1)), 1);
    do_read(32'(4 * (MEM - 1)), 2, 0);
    vecs = '{'{32'h0, 4, 1'b0}, '{32'h34, 2, 1'b0}, '{32'h1002, 1, 1'b1}, '{32'h1000, 1, 1'b1},
             '{32'hFFC, 2, 1'b0}, '{32'h1, 3, 1'b1}, '{32'hFFFF_FFFC, 1, 1'b1}, '{32'h400, 256, 1'b0},
             '{32'h8, 1, 1'b0}};
    for (int v = 0; v < 9; v++) do_read(vecs[v].addr, vecs[v].len, vecs[v].err);
    end_at_begin = 1;
    do_read(32'h10, 3, 0);
    end_at_begin = 0;
    @(posedge clk); #1;
    bus.begin_transaction = 1; bus.address_data = 32'h40; bus.burst_size = 8'd7; bus.read_not_write = 1;
    for (int k = 1; k <= RL; k++) begin @(posedge clk); #1; bus.begin_transaction = 0; end
    check("abort_word0", outs(), {1'b1, model_mem[16], 3'b0});
    bus.end_transaction = 1;
    @(posedge clk); #1; bus.end_transaction = 0;
    check("abort_quiet1", outs(), 36'h0);
    @(posedge clk); #1;
    check("abort_quiet2", outs(), 36'h0);
    @(posedge clk); #1;
    bus.begin_transaction = 1; bus.address_data = 32'h80; bus.burst_size = 8'd3; bus.read_not_write = 0;
    @(posedge clk); #1;
    bus.begin_transaction = 0; bus.data_valid = 1; bus.byte_enables = 4'hF; bus.address_data = 32'hA5A5_0001;
    model_mem[32] = 32'hA5A5_0001;
    @(posedge clk); #1; bus.data_valid = 0; bus.end_transaction = 1;
    @(posedge clk); #1; bus.end_transaction = 0;
    do_read(32'h80, 4, 0);
    @(posedge clk); #1;
    bus.begin_transaction = 1; bus.address_data = 32'h0; bus.burst_size = 8'd3; bus.read_not_write = 1;
    for (int k = 1; k <= RL + 1; k++) begin @(posedge clk); #1; bus.begin_transaction = 0; end
    check("rst_word1", outs(), {1'b1, model_mem[1], 3'b0});
    #2 rst_n = 0;
    #1 check("rst_async", outs(), 36'h0);
    @(posedge clk); #1;
    check("rst_hold", outs(), 36'h0);
    rst_n = 1;
    @(posedge clk); #1;
    check("rst_after", outs(), 36'h0);
    do_read(32'h0, 4, 0);
    for (int n = 0; n < 40; n++) begin
      int r, len;
      logic [31:0] addr;
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        len = int'($urandom_range(1, 12));
        for (int i = 0; i < len; i++) begin wd[i] = $urandom(); wb[i] = 4'($urandom_range(0, 15)); end
        do_write(32'($urandom_range(0, MEM - 1)) << 2, len);
      end else begin
        addr = r == 4 ? $urandom() : r == 5 ? (32'($urandom_range(0, MEM - 1)) << 2) | 32'($urandom_range(1, 3))
                                            : 32'($urandom_range(0, MEM - 1)) << 2;
        do_read(addr, int'($urandom_range(1, 16)), addr[1:0] != 2'b00 || (addr >> 2) >= 32'(MEM));
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
